topk_drain: RTL and testbench



---
 rtl/topk_drain.sv | 146 ++++++++++++++
 tb/tb_topk_drain.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/topk_drain.sv
// ============================================================================
// topk_drain: keeps the K largest unsigned samples and drains them in
// descending order over valid/ready. Optional macro: TOPK_DROP_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module topk_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int K          = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    din_valid,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    drain_start,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    dout_last,
  output logic                    busy,
  output logic [$clog2(K+1)-1:0]  count
`ifdef TOPK_DROP_CNT_EN
  ,
  output logic [7:0]              drop_cnt
`endif
);

  localparam int CW = $clog2(K+1);

  typedef enum logic [0:0] {COLLECT = 1'b0, DRAIN = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] slot_q [K];
  logic [DATA_WIDTH-1:0] slot_d [K];
  logic [DATA_WIDTH-1:0] slot_sh [K];
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         ptr_q, ptr_d;
  logic [CW-1:0]         ins_pos;
  logic [DATA_WIDTH-1:0] cur_word;
  logic                  is_last;
  logic                  beat;
`ifdef TOPK_DROP_CNT_EN
  logic [7:0]            drop_q, drop_d;
`endif

  // Ties sort the new sample ahead of equal entries, so only strictly-greater
  // valid slots push the insertion point down.
  always_comb begin
    ins_pos = '0;
    for (int i = 0; i < K; i++) begin
      if ((CW'(i) < count_q) && (slot_q[i] > din))
        ins_pos = ins_pos + CW'(1);
    end
  end

  always_comb begin
    slot_sh[0] = '0;
    for (int i = 1; i < K; i++) slot_sh[i] = slot_q[i-1];
  end

  always_comb begin
    cur_word = '0;
    for (int i = 0; i < K; i++) begin
      if (CW'(i) == ptr_q) cur_word = slot_q[i];
    end
  end

  assign is_last = (ptr_q == count_q - CW'(1));
  assign beat    = (state_q == DRAIN) && dout_ready;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    count_d = count_q;
    ptr_d   = ptr_q;
`ifdef TOPK_DROP_CNT_EN
    drop_d  = drop_q;
`endif
    case (state_q)
      COLLECT: begin
        if (din_valid && !((count_q == CW'(K)) && (ins_pos == CW'(K)))) begin
          for (int i = 0; i < K; i++) begin
            if (CW'(i) == ins_pos)     slot_d[i] = din;
            else if (CW'(i) > ins_pos) slot_d[i] = slot_sh[i];
          end
          if (count_q != CW'(K)) count_d = count_q + CW'(1);
        end
        // A same-cycle sample is already counted in count_d.
        if (drain_start && (count_d != '0)) begin
          state_d = DRAIN;
          ptr_d   = '0;
        end
      end
      DRAIN: begin
`ifdef TOPK_DROP_CNT_EN
        if (din_valid && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
`endif
        if (beat) begin
          if (is_last) begin
            for (int i = 0; i < K; i++) slot_d[i] = '0;
            count_d = '0;
            ptr_d   = '0;
            state_d = COLLECT;
          end else begin
            ptr_d = ptr_q + CW'(1);
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= COLLECT;
      for (int i = 0; i < K; i++) slot_q[i] <= '0;
      count_q <= '0;
      ptr_q   <= '0;
`ifdef TOPK_DROP_CNT_EN
      drop_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
`ifdef TOPK_DROP_CNT_EN
      drop_q  <= drop_d;
`endif
    end
  end

  // Outputs are forced low while reset is asserted.
  assign dout_valid = resetn && (state_q == DRAIN);
  assign busy       = resetn && (state_q == DRAIN);
  assign dout       = (resetn && (state_q == DRAIN)) ? cur_word : '0;
  assign dout_last  = resetn && (state_q == DRAIN) && is_last;
  assign count      = resetn ? count_q : '0;
`ifdef TOPK_DROP_CNT_EN
  assign drop_cnt   = resetn ? drop_q : 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_topk_drain.sv
// Directed bench for topk_drain (K=4, 32-bit): inputs driven and outputs
// sampled on the falling edge.
`default_nettype none

module tb_topk_drain;

  logic        clk = 1'b0;
  logic        resetn;
  logic        din_valid;
  logic [31:0] din;
  logic        drain_start;
  logic        dout_valid;
  logic        dout_ready;
  logic [31:0] dout;
  logic        dout_last;
  logic        busy;
  logic [2:0]  count;
`ifdef TOPK_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  topk_drain #(.DATA_WIDTH(32), .K(4)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .din_valid   (din_valid),
    .din         (din),
    .drain_start (drain_start),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout        (dout),
    .dout_last   (dout_last),
    .busy        (busy),
    .count       (count)
`ifdef TOPK_DROP_CNT_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic feed(input logic [31:0] v);
    din_valid = 1'b1;
    din       = v;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic start_drain();
    drain_start = 1'b1;
    @(negedge clk);
    drain_start = 1'b0;
  endtask

  // Checks the word on offer, then lets one edge pass (a beat if ready=1).
  task automatic expect_beat(input string tag, input logic [31:0] v, input logic last);
    chk({tag, "_valid"}, {31'd0, dout_valid}, 32'd1);
    chk({tag, "_dout"},  dout, v);
    chk({tag, "_last"},  {31'd0, dout_last}, {31'd0, last});
    @(negedge clk);
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_valid"}, {31'd0, dout_valid}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_count"}, {29'd0, count}, 32'd0);
  endtask

  initial begin
    resetn = 1'b0; din_valid = 1'b0; din = '0; drain_start = 1'b0; dout_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    expect_idle("reset");
    chk("reset_dout", dout, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Ranking with a tie and an eviction: 5,9,1,9,3 -> 9,9,5,3
    feed(32'd5); feed(32'd9); feed(32'd1); feed(32'd9); feed(32'd3);
    chk("t1_count", {29'd0, count}, 32'd4);
    dout_ready = 1'b1;
    start_drain();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    expect_beat("t1_b0", 32'd9, 1'b0);
    expect_beat("t1_b1", 32'd9, 1'b0);
    expect_beat("t1_b2", 32'd5, 1'b0);
    expect_beat("t1_b3", 32'd3, 1'b1);
    expect_idle("t1_end");

    // Partial fill: 7,2
    feed(32'd7); feed(32'd2);
    chk("t2_count", {29'd0, count}, 32'd2);
    start_drain();
    expect_beat("t2_b0", 32'd7, 1'b0);
    expect_beat("t2_b1", 32'd2, 1'b1);
    expect_idle("t2_end");

    // Drain request on empty storage is ignored
    start_drain();
    expect_idle("t3_a");
    @(negedge clk);
    expect_idle("t3_b");

    // Sample in the same cycle as drain_start joins the drain
    feed(32'd4);
    din_valid = 1'b1; din = 32'd8;
    start_drain();
    din_valid = 1'b0;
    chk("t4_count", {29'd0, count}, 32'd2);
    expect_beat("t4_b0", 32'd8, 1'b0);
    expect_beat("t4_b1", 32'd4, 1'b1);
    expect_idle("t4_end");

    // Back-pressure: dout stable for 3 stalled cycles; sample dropped in DRAIN
    feed(32'd10); feed(32'd20); feed(32'd30);
    dout_ready = 1'b0;
    start_drain();
    for (int i = 0; i < 3; i++) begin
      chk("t5_hold_valid", {31'd0, dout_valid}, 32'd1);
      chk("t5_hold_dout", dout, 32'd30);
      if (i == 0) begin din_valid = 1'b1; din = 32'hFFFF_FFFF; end
      @(negedge clk);
      din_valid = 1'b0;
    end
    chk("t5_count", {29'd0, count}, 32'd3);
    dout_ready = 1'b1;
    expect_beat("t5_b0", 32'd30, 1'b0);
    expect_beat("t5_b1", 32'd20, 1'b0);
    expect_beat("t5_b2", 32'd10, 1'b1);
    expect_idle("t5_end");
`ifdef TOPK_DROP_CNT_EN
    chk("t5_drop", {24'd0, drop_cnt}, 32'd1);
`endif

    // Reset mid-drain abandons the partial drain
    feed(32'd1); feed(32'd2); feed(32'd3); feed(32'd4);
    start_drain();
    expect_beat("t6_b0", 32'd4, 1'b0);
    resetn = 1'b0;
    @(negedge clk);
    expect_idle("t6_rst");
    resetn = 1'b1;
`ifdef TOPK_DROP_CNT_EN
    chk("t6_drop", {24'd0, drop_cnt}, 32'd0);
`endif
    @(negedge clk);
    feed(32'd6);
    chk("t6_count", {29'd0, count}, 32'd1);
    start_drain();
    expect_beat("t6_only", 32'd6, 1'b1);
    expect_idle("t6_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
